rram_read_sequencer: RTL

- Sequences one RRAM array read for the RRAM_CONTROLLER in one of two modes: a CSA binary read, or an ADC multi-level compute read.
- Each read runs bias setup, precharge, settle, sense/convert, capture and release, driving the RRAM_ANALOG control pins (enables, level codes, PRE, SAEN_CSA, CLK_EN_ADC).
- Captured results are buffered in a small first-word-fall-through FIFO, which the Wishbone side drains.

---
 rtl/rram_read_sequencer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rram_read_sequencer.sv
// rram_read_sequencer
// Sequences one RRAM array read (CSA binary read or ADC multi-level compute
// read). It drives the analog control pins through bias setup, precharge,
// settle, sense/convert, capture and release. Results go into a small
// first-word-fall-through FIFO that the bus side drains.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, mode, wl_sel       read request, mode (0 CSA / 1 ADC), word lines
//   clr_ovf                   clears the sticky overflow flag
//   busy, done, err           status: busy outside IDLE, done pulse, reject pulse
//   ENABLE_*, IN1_*, IN0_*    analog driver enables and 2-bit level codes
//   PRE, SAEN_CSA, CLK_EN_ADC precharge, CSA sense enable, ADC phase clocks
//   CSA, ADC_OUT0..2          analog results
//   rd_en, rd_data            FIFO pop and FIFO head
//   fifo_empty, fifo_full     FIFO flags
//   overflow                  sticky: a result was dropped because FIFO was full
//   dbg_state                 current FSM state
//
// Handshakes: start is a request sampled only in IDLE (ignored while busy);
// rd_en pops the head on the clock edge whenever the FIFO is non-empty and is
// ignored when empty. Neither side has a ready/backpressure return path.
module rram_read_sequencer #(
    parameter int PRE_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int SENSE_CYCLES  = 2,
    parameter int ADC_CYCLES    = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] wl_sel,
    input  logic        clr_ovf,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ENABLE_WL,
    output logic        ENABLE_SL,
    output logic        ENABLE_BL,
    output logic [15:0] IN1_WL,
    output logic [15:0] IN0_WL,
    output logic [15:0] IN1_SL,
    output logic [15:0] IN0_SL,
    output logic [15:0] IN1_BL,
    output logic [15:0] IN0_BL,
    output logic        PRE,
    output logic        SAEN_CSA,
    output logic [1:0]  CLK_EN_ADC,
    input  logic [15:0] CSA,
    input  logic [15:0] ADC_OUT0,
    input  logic [15:0] ADC_OUT1,
    input  logic [15:0] ADC_OUT2,
    input  logic        rd_en,
    output logic [47:0] rd_data,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        overflow,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_PRECHARGE, S_SETTLE, S_SENSE,
        S_ADC_PH0, S_ADC_PH1, S_CAPTURE, S_RELEASE, S_DONE
    } state_t;

    localparam int CNT_W = 16;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    state_t             state;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt;

    assign dbg_state = state;

    // Sequencer. Every output is assigned on the same edge as the state it
    // belongs to, so pins change exactly at phase boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ENABLE_WL  <= 1'b0;
            ENABLE_SL  <= 1'b0;
            ENABLE_BL  <= 1'b0;
            IN1_WL     <= '0;
            IN0_WL     <= '0;
            IN1_SL     <= '0;
            IN0_SL     <= '0;
            IN1_BL     <= '0;
            IN0_BL     <= '0;
            PRE        <= 1'b0;
            SAEN_CSA   <= 1'b0;
            CLK_EN_ADC <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (wl_sel == '0) begin
                            err <= 1'b1;
                        end else begin
                            state     <= S_SETUP;
                            busy      <= 1'b1;
                            mode_q    <= mode;
                            ENABLE_WL <= 1'b1;
                            ENABLE_SL <= 1'b1;
                            ENABLE_BL <= 1'b1;
                            // Selected word lines at V4 (11), others V1 (00)
                            IN1_WL    <= wl_sel;
                            IN0_WL    <= wl_sel;
                            // Bit lines at V2 (01), source lines at V1 (00)
                            IN1_BL    <= '0;
                            IN0_BL    <= '1;
                            IN1_SL    <= '0;
                            IN0_SL    <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_PRECHARGE;
                    PRE   <= 1'b1;
                    cnt   <= CNT_W'(PRE_CYCLES - 1);
                end
                S_PRECHARGE: begin
                    if (cnt == '0) begin
                        state <= S_SETTLE;
                        PRE   <= 1'b0;
                        cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        if (mode_q) begin
                            state      <= S_ADC_PH0;
                            CLK_EN_ADC <= 2'b01;
                            cnt        <= CNT_W'(ADC_CYCLES - 1);
                        end else begin
                            state    <= S_SENSE;
                            SAEN_CSA <= 1'b1;
                            cnt      <= CNT_W'(SENSE_CYCLES - 1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SENSE: begin
                    if (cnt == '0) begin
                        state    <= S_CAPTURE;
                        SAEN_CSA <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ADC_PH0: begin
                    if (cnt == '0) begin
                        state      <= S_ADC_PH1;
                        CLK_EN_ADC <= 2'b10;
                        cnt        <= CNT_W'(ADC_CYCLES - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ADC_PH1: begin
                    if (cnt == '0) begin
                        state      <= S_CAPTURE;
                        CLK_EN_ADC <= 2'b00;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    // The FIFO takes the result on this same edge.
                    state     <= S_RELEASE;
                    ENABLE_WL <= 1'b0;
                    ENABLE_SL <= 1'b0;
                    ENABLE_BL <= 1'b0;
                    IN1_WL    <= '0;
                    IN0_WL    <= '0;
                    IN1_SL    <= '0;
                    IN0_SL    <= '0;
                    IN1_BL    <= '0;
                    IN0_BL    <= '0;
                end
                S_RELEASE: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result FIFO
    logic [47:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [AW:0]   count, count_nx;
    logic          wr_req, pop, wr_ok, ovf_set;
    logic [47:0]   wr_data;

    always_comb begin
        wr_req    = (state == S_CAPTURE);
        wr_data   = mode_q ? {ADC_OUT2, ADC_OUT1, ADC_OUT0} : {32'h0, CSA};
        pop       = rd_en && (count != '0);
        // A pop in the same cycle frees the slot a full FIFO needs.
        wr_ok     = wr_req && ((count != FULL_COUNT) || pop);
        ovf_set   = wr_req && (count == FULL_COUNT) && !pop;
        rd_ptr_nx = pop ? rd_ptr + AW'(1) : rd_ptr;
        case ({wr_ok, pop})
            2'b10:   count_nx = count + (AW+1)'(1);
            2'b01:   count_nx = count - (AW+1)'(1);
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_ptr_nx;
            count      <= count_nx;
            fifo_empty <= (count_nx == '0);
            fifo_full  <= (count_nx == FULL_COUNT);
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            // rd_data is registered: preload the next head. The head can be
            // the entry being written this edge (FIFO empty, or one entry
            // being popped while a new one arrives). When empty it holds.
            if (count_nx != '0)
                rd_data <= (wr_ok && (wr_ptr == rd_ptr_nx)) ? wr_data : mem[rd_ptr_nx];
        end
    end

endmodule
